// File: rtl/tri_skew_buffer_if.sv
// tri_skew_buffer_if: handshake/data bundle for tri_skew_buffer.
//   hold       global stall
//   flush      clear all lanes, keep mode
//   mode_set   request to load mode_in (0 DOWN, 1 UP)
//   enable_in / data_in    per-lane input valid and data
//   enable_out / data_out  per-lane output valid and data
//   mode, busy, occupancy, mode_err  status
// slave = the buffer, master = the driver of the buffer.
interface tri_skew_buffer_if #(
    parameter int BIT_WIDTH  = 32,
    parameter int TRI_LENGTH = 16
) ();
    localparam int OCC_W = $clog2(TRI_LENGTH * (TRI_LENGTH + 1) / 2 + 1);

    logic                                 hold;
    logic                                 flush;
    logic                                 mode_set;
    logic                                 mode_in;
    logic [TRI_LENGTH-1:0]                enable_in;
    logic [TRI_LENGTH-1:0][BIT_WIDTH-1:0] data_in;
    logic [TRI_LENGTH-1:0]                enable_out;
    logic [TRI_LENGTH-1:0][BIT_WIDTH-1:0] data_out;
    logic                                 mode;
    logic                                 busy;
    logic [OCC_W-1:0]                     occupancy;
    logic                                 mode_err;

    modport slave (
        input  hold, flush, mode_set, mode_in, enable_in, data_in,
        output enable_out, data_out, mode, busy, occupancy, mode_err
    );

    modport master (
        output hold, flush, mode_set, mode_in, enable_in, data_in,
        input  enable_out, data_out, mode, busy, occupancy, mode_err
    );
endinterface

// File: rtl/tri_skew_buffer.sv
// tri_skew_buffer: triangular skew/deskew buffer for a systolic-array edge.
// Lane i delays its (enable, data) stream by TRI_LENGTH-i advancing cycles in
// DOWN mode (mode=0) or i+1 in UP mode (mode=1). Supports a global stall
// (hold), flush, occupancy count and busy flag.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   tri_skew_buffer_if.slave (stall/flush/mode control, lane data in/out,
//         mode/busy/occupancy/mode_err status)
module tri_skew_buffer #(
    parameter int BIT_WIDTH  = 32,
    parameter int TRI_LENGTH = 16,
    parameter int RESET_MODE = 0
) (
    input logic              clk,
    input logic              rst,
    tri_skew_buffer_if.slave bus
);
    localparam int OCC_W = $clog2(TRI_LENGTH * (TRI_LENGTH + 1) / 2 + 1);

    logic                                 mode_q;
    logic                                 busy_q;
    logic                                 err_q;
    logic [OCC_W-1:0]                     occ_q;
    logic [OCC_W-1:0]                     occ_nxt;
    logic [OCC_W-1:0]                     in_cnt;
    logic [OCC_W-1:0]                     out_cnt;
    logic                                 mode_ok;
    logic [TRI_LENGTH-1:0]                eo_all;
    logic [TRI_LENGTH-1:0][BIT_WIDTH-1:0] do_all;

    for (genvar i = 0; i < TRI_LENGTH; i++) begin : g_lane
        logic [TRI_LENGTH-1:0]                vld_q;
        logic [TRI_LENGTH-1:0]                vld_d;
        logic [TRI_LENGTH-1:0][BIT_WIDTH-1:0] dat_q;
        logic [TRI_LENGTH-1:0][BIT_WIDTH-1:0] dat_d;
        logic                                 eo_q;
        logic [BIT_WIDTH-1:0]                 do_q;
        logic                                 tap_v;
        logic [BIT_WIDTH-1:0]                 tap_d;
        int                                   tap;

        assign tap = mode_q ? i : TRI_LENGTH - 1 - i;

        // Stages past the tap load zero, so nothing stale is left behind the
        // tap. A later mode change (only allowed when empty) then cannot
        // expose old valids at a deeper tap.
        always_comb begin
            vld_d    = '0;
            dat_d    = '0;
            vld_d[0] = bus.enable_in[i];
            dat_d[0] = bus.enable_in[i] ? bus.data_in[i] : '0;
            for (int k = 1; k < TRI_LENGTH; k++) begin
                if (k <= tap) begin
                    vld_d[k] = vld_q[k-1];
                    dat_d[k] = dat_q[k-1];
                end
            end
            tap_v = 1'b0;
            tap_d = '0;
            for (int k = 0; k < TRI_LENGTH; k++) begin
                if (k == tap) begin
                    tap_v = vld_d[k];
                    tap_d = dat_d[k];
                end
            end
        end

        // Output register mirrors the next value of the tap stage, so the
        // outputs come straight from flops.
        always_ff @(posedge clk) begin
            if (rst || bus.flush) begin
                vld_q <= '0;
                dat_q <= '0;
                eo_q  <= 1'b0;
                do_q  <= '0;
            end else if (!bus.hold) begin
                vld_q <= vld_d;
                dat_q <= dat_d;
                eo_q  <= tap_v;
                do_q  <= tap_d;
            end
        end

        assign eo_all[i] = eo_q;
        assign do_all[i] = do_q;
    end

    // enable_out is exactly the set of valids sitting at the taps, i.e. the
    // entries leaving on the next advance.
    always_comb begin
        in_cnt  = '0;
        out_cnt = '0;
        for (int k = 0; k < TRI_LENGTH; k++) begin
            in_cnt  = in_cnt + OCC_W'(bus.enable_in[k]);
            out_cnt = out_cnt + OCC_W'(eo_all[k]);
        end
        occ_nxt = occ_q + in_cnt - out_cnt;
    end

    assign mode_ok = !busy_q && (bus.enable_in == '0);

    // A mode request is evaluated on flush cycles (against pre-flush busy)
    // and on advancing cycles; a held cycle ignores it silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= 1'(RESET_MODE);
            occ_q  <= '0;
            busy_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (bus.mode_set && (bus.flush || !bus.hold)) begin
                if (mode_ok) mode_q <= bus.mode_in;
                else         err_q  <= 1'b1;
            end
            if (bus.flush) begin
                occ_q  <= '0;
                busy_q <= 1'b0;
            end else if (!bus.hold) begin
                occ_q  <= occ_nxt;
                busy_q <= (occ_nxt != '0);
            end
        end
    end

    assign bus.enable_out = eo_all;
    assign bus.data_out   = do_all;
    assign bus.mode       = mode_q;
    assign bus.busy       = busy_q;
    assign bus.occupancy  = occ_q;
    assign bus.mode_err   = err_q;
endmodule

// File: tb/tb_tri_skew_buffer.sv
module tb_tri_skew_buffer;
    localparam int T = 4;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    tri_skew_buffer_if #(.BIT_WIDTH(W), .TRI_LENGTH(T)) bus ();

    tri_skew_buffer #(.BIT_WIDTH(W), .TRI_LENGTH(T), .RESET_MODE(0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Reference model: list of in-flight samples, each with its age in
    // advancing edges (1 right after capture) and its lane delay.
    typedef struct {
        int           lane;
        logic [W-1:0] data;
        int           age;
        int           dly;
    } item_t;

    item_t mq[$];
    logic  m_mode = 1'b0;
    logic  m_err  = 1'b0;

    function automatic int dly_of(int lane, logic md);
        return md ? lane + 1 : T - lane;
    endfunction

    function automatic logic exp_en(int lane);
        foreach (mq[j]) if (mq[j].lane == lane && mq[j].age == mq[j].dly) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [W-1:0] exp_dat(int lane);
        foreach (mq[j]) if (mq[j].lane == lane && mq[j].age == mq[j].dly) return mq[j].data;
        return '0;
    endfunction

    function automatic logic [T-1:0][W-1:0] rnd_data();
        logic [T-1:0][W-1:0] r;
        for (int i = 0; i < T; i++) r[i] = W'($urandom);
        return r;
    endfunction

    function automatic logic [T-1:0][W-1:0] ramp_data(int base);
        logic [T-1:0][W-1:0] r;
        for (int i = 0; i < T; i++) r[i] = W'(base + i);
        return r;
    endfunction

    // One clock edge: drive inputs, advance the model, settle after the edge.
    task automatic step(input logic h, input logic f, input logic ms, input logic mi,
                        input logic [T-1:0] en, input logic [T-1:0][W-1:0] d);
        item_t nq[$];
        @(negedge clk);
        bus.hold      = h;
        bus.flush     = f;
        bus.mode_set  = ms;
        bus.mode_in   = mi;
        bus.enable_in = en;
        bus.data_in   = d;
        m_err = 1'b0;
        if (ms && (f || !h)) begin
            if (mq.size() == 0 && en == '0) m_mode = mi;
            else                            m_err  = 1'b1;
        end
        if (f) begin
            mq.delete();
        end else if (!h) begin
            foreach (mq[j]) begin
                item_t it;
                it = mq[j];
                it.age++;
                if (it.age <= it.dly) nq.push_back(it);
            end
            for (int i = 0; i < T; i++)
                if (en[i]) nq.push_back('{lane: i, data: d[i], age: 1, dly: dly_of(i, m_mode)});
            mq = nq;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, '0, rnd_data());
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst           = 1'b1;
        bus.hold      = 1'b0;
        bus.flush     = 1'b0;
        bus.mode_set  = 1'b1;
        bus.mode_in   = 1'b1;
        bus.enable_in = '1;
        bus.data_in   = rnd_data();
        @(posedge clk);
        #1;
        rst = 1'b0;
        mq.delete();
        m_mode = 1'b0;
        m_err  = 1'b0;
        checks++;
        if (bus.enable_out !== '0 || bus.data_out !== '0 || bus.mode !== 1'b0 ||
            bus.busy !== 1'b0 || bus.occupancy !== '0 || bus.mode_err !== 1'b0) begin
            errors++;
            $display("FAIL reset: got en=%h data=%h mode=%b busy=%b occ=%0d err=%b, want all zero",
                     bus.enable_out, bus.data_out, bus.mode, bus.busy, bus.occupancy, bus.mode_err);
        end
    endtask

    task automatic test_down_pulse();
        int          occ_t[5] = '{4, 3, 2, 1, 0};
        logic [T-1:0] en_t[5] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0000};
        for (int c = 0; c < 5; c++) begin
            if (c == 0) step(1'b0, 1'b0, 1'b0, 1'b0, '1, ramp_data(8'h10));
            else        idle();
            checks++;
            if (bus.enable_out !== en_t[c] || bus.occupancy !== 4'(occ_t[c]) ||
                bus.busy !== (occ_t[c] != 0)) begin
                errors++;
                $display("FAIL down_pulse c%0d: got en=%b occ=%0d busy=%b, want en=%b occ=%0d",
                         c, bus.enable_out, bus.occupancy, bus.busy, en_t[c], occ_t[c]);
            end
            for (int i = 0; i < T; i++) begin
                checks++;
                if (bus.data_out[i] !== (en_t[c][i] ? W'(8'h10 + i) : W'(0))) begin
                    errors++;
                    $display("FAIL down_pulse data c%0d lane%0d: got %h", c, i, bus.data_out[i]);
                end
            end
        end
    endtask

    task automatic test_up_pulse();
        logic [T-1:0] en_t[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
        step(1'b0, 1'b0, 1'b1, 1'b1, '0, rnd_data());
        checks++;
        if (bus.mode !== 1'b1 || bus.mode_err !== 1'b0) begin
            errors++;
            $display("FAIL up_set: got mode=%b err=%b, want mode=1 err=0", bus.mode, bus.mode_err);
        end
        for (int c = 0; c < 5; c++) begin
            if (c == 0) step(1'b0, 1'b0, 1'b0, 1'b0, '1, ramp_data(8'h10));
            else        idle();
            checks++;
            if (bus.enable_out !== en_t[c]) begin
                errors++;
                $display("FAIL up_pulse c%0d: got en=%b want %b", c, bus.enable_out, en_t[c]);
            end
            for (int i = 0; i < T; i++) begin
                checks++;
                if (bus.data_out[i] !== exp_dat(i)) begin
                    errors++;
                    $display("FAIL up_pulse data c%0d lane%0d: got %h want %h",
                             c, i, bus.data_out[i], exp_dat(i));
                end
            end
        end
    endtask

    task automatic test_stream();
        for (int c = 0; c < 24; c++) begin
            if (c < 20) step(1'b0, 1'b0, 1'b0, 1'b0, '1, ramp_data(c * 4));
            else        idle();
            if (c >= 3 && c < 20) begin
                checks++;
                if (bus.occupancy !== 4'd10 || bus.enable_out !== 4'b1111) begin
                    errors++;
                    $display("FAIL stream steady c%0d: got occ=%0d en=%b, want occ=10 en=1111",
                             c, bus.occupancy, bus.enable_out);
                end
            end
            for (int i = 0; i < T; i++) begin
                checks++;
                if (bus.enable_out[i] !== exp_en(i) || bus.data_out[i] !== exp_dat(i)) begin
                    errors++;
                    $display("FAIL stream c%0d lane%0d: got en=%b data=%h want en=%b data=%h",
                             c, i, bus.enable_out[i], bus.data_out[i], exp_en(i), exp_dat(i));
                end
            end
        end
    endtask

    task automatic test_hold();
        int occ_before = 0;
        for (int c = 0; c < 16; c++) begin
            logic h;
            h = (c >= 4 && c < 7);
            if (c == 4) occ_before = mq.size();
            if (c < 10) step(h, 1'b0, h, 1'b0, '1, rnd_data());
            else        idle();
            if (h) begin
                checks++;
                if (bus.occupancy !== 4'(occ_before) || bus.mode_err !== 1'b0) begin
                    errors++;
                    $display("FAIL hold c%0d: got occ=%0d err=%b want occ=%0d err=0",
                             c, bus.occupancy, bus.mode_err, occ_before);
                end
            end
            for (int i = 0; i < T; i++) begin
                checks++;
                if (bus.enable_out[i] !== exp_en(i) || bus.data_out[i] !== exp_dat(i)) begin
                    errors++;
                    $display("FAIL hold c%0d lane%0d: got en=%b data=%h want en=%b data=%h",
                             c, i, bus.enable_out[i], bus.data_out[i], exp_en(i), exp_dat(i));
                end
            end
        end
    endtask

    task automatic test_mode_err();
        step(1'b0, 1'b0, 1'b1, 1'b0, '0, rnd_data());
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0110, rnd_data());
        checks++;
        if (bus.mode !== 1'b0 || bus.occupancy !== 4'd2) begin
            errors++;
            $display("FAIL mode_err setup: got mode=%b occ=%0d want mode=0 occ=2", bus.mode, bus.occupancy);
        end
        step(1'b0, 1'b0, 1'b1, 1'b1, '0, rnd_data());
        checks++;
        if (bus.mode_err !== 1'b1 || bus.mode !== 1'b0) begin
            errors++;
            $display("FAIL mode_err busy: got err=%b mode=%b want err=1 mode=0", bus.mode_err, bus.mode);
        end
        step(1'b1, 1'b0, 1'b1, 1'b1, '0, rnd_data());
        checks++;
        if (bus.mode_err !== 1'b0 || bus.mode !== 1'b0) begin
            errors++;
            $display("FAIL mode_err pulse/hold: got err=%b mode=%b want err=0 mode=0", bus.mode_err, bus.mode);
        end
        for (int c = 0; c < 4; c++) idle();
        step(1'b0, 1'b0, 1'b1, 1'b1, 4'b0001, rnd_data());
        checks++;
        if (bus.mode_err !== 1'b1 || bus.mode !== 1'b0) begin
            errors++;
            $display("FAIL mode_err enable: got err=%b mode=%b want err=1 mode=0", bus.mode_err, bus.mode);
        end
        for (int c = 0; c < 5; c++) idle();
        step(1'b0, 1'b0, 1'b1, 1'b1, '0, rnd_data());
        checks++;
        if (bus.mode_err !== 1'b0 || bus.mode !== 1'b1 || m_mode !== 1'b1) begin
            errors++;
            $display("FAIL mode_err retry: got err=%b mode=%b want err=0 mode=1", bus.mode_err, bus.mode);
        end
    endtask

    task automatic test_flush();
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'b1110, rnd_data());
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'b1110, rnd_data());
        checks++;
        if (bus.occupancy !== 4'd6 || bus.occupancy !== 4'(mq.size())) begin
            errors++;
            $display("FAIL flush setup: got occ=%0d want 6", bus.occupancy);
        end
        step(1'b1, 1'b1, 1'b1, 1'b0, '1, rnd_data());
        checks++;
        if (bus.enable_out !== '0 || bus.data_out !== '0 || bus.occupancy !== '0 ||
            bus.busy !== 1'b0 || bus.mode !== 1'b1 || bus.mode_err !== 1'b1) begin
            errors++;
            $display("FAIL flush: got en=%h data=%h occ=%0d busy=%b mode=%b err=%b want zeros mode=1 err=1",
                     bus.enable_out, bus.data_out, bus.occupancy, bus.busy, bus.mode, bus.mode_err);
        end
        for (int c = 0; c < 3; c++) step(1'b0, 1'b0, 1'b0, 1'b0, '1, rnd_data());
        test_reset();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            logic h, f, ms;
            h  = ($urandom_range(0, 4) == 0);
            f  = ($urandom_range(0, 22) == 0);
            ms = ($urandom_range(0, 9) == 0);
            step(h, f, ms, 1'($urandom), ($urandom_range(0, 2) == 0) ? '0 : 4'($urandom), rnd_data());
            checks++;
            if (bus.mode !== m_mode || bus.mode_err !== m_err ||
                bus.occupancy !== 4'(mq.size()) || bus.busy !== (mq.size() != 0)) begin
                errors++;
                $display("FAIL random status c%0d: got mode=%b err=%b occ=%0d busy=%b want mode=%b err=%b occ=%0d",
                         c, bus.mode, bus.mode_err, bus.occupancy, bus.busy, m_mode, m_err, mq.size());
            end
            for (int i = 0; i < T; i++) begin
                checks++;
                if (bus.enable_out[i] !== exp_en(i) || bus.data_out[i] !== exp_dat(i)) begin
                    errors++;
                    $display("FAIL random c%0d lane%0d: got en=%b data=%h want en=%b data=%h",
                             c, i, bus.enable_out[i], bus.data_out[i], exp_en(i), exp_dat(i));
                end
            end
        end
    endtask

    initial begin
        bus.hold      = 1'b0;
        bus.flush     = 1'b0;
        bus.mode_set  = 1'b0;
        bus.mode_in   = 1'b0;
        bus.enable_in = '0;
        bus.data_in   = '0;
        test_reset();
        test_down_pulse();
        test_up_pulse();
        test_stream();
        test_hold();
        test_mode_err();
        test_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
